// File: rtl/onewire_bus_scheduler.sv
// onewire_bus_scheduler
//   Shares the one-wire bus between two requesters. A granted transaction runs
//   bus reset, presence check, up to MAX_BYTES write bytes, then up to
//   MAX_BYTES read bytes. Each step is handed to an external engine through an
//   enable/done handshake. After every transaction the bus is left idle for
//   GAP_CYCLES cycles before the next grant is issued.
// Ports
//   clk, rst_n                  clock, asynchronous active-low reset
//   req[1:0]                    per-requester request, held until done
//   wr_len0/1, rd_len0/1        byte counts per requester, clamped to MAX_BYTES
//   wr_data0/1                  write bytes, byte 0 in [7:0] is sent first
//   gnt[1:0], done[1:0]         one-hot grant, one-cycle completion pulse
//   err, rd_data                no-presence flag and read bytes, valid with done
//   reset_enable/done/presence  reset engine handshake
//   write_enable/byte/done      byte-write engine handshake
//   read_enable/done/byte       byte-read engine handshake
module onewire_bus_scheduler #(
    parameter int unsigned MAX_BYTES  = 4,
    parameter int unsigned GAP_CYCLES = 27
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [1:0]             req,
    input  logic [2:0]             wr_len0,
    input  logic [2:0]             wr_len1,
    input  logic [2:0]             rd_len0,
    input  logic [2:0]             rd_len1,
    input  logic [8*MAX_BYTES-1:0] wr_data0,
    input  logic [8*MAX_BYTES-1:0] wr_data1,
    output logic [1:0]             gnt,
    output logic [1:0]             done,
    output logic                   err,
    output logic [8*MAX_BYTES-1:0] rd_data,
    output logic                   reset_enable,
    input  logic                   reset_done,
    input  logic                   reset_presence,
    output logic                   write_enable,
    output logic [7:0]             write_byte,
    input  logic                   write_done,
    output logic                   read_enable,
    input  logic                   read_done,
    input  logic [7:0]             read_byte
);

    localparam int unsigned DW = 8 * MAX_BYTES;
    localparam int unsigned CW = $clog2(MAX_BYTES + 1);
    localparam int unsigned GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    typedef enum logic [2:0] {
        StIdle, StRst, StWrGap, StWr, StRdGap, StRd, StFin, StRecover
    } state_e;

    state_e          state_q, state_d;
    logic            sel_q, sel_d;      // granted requester index
    logic            last_q, last_d;    // last served requester
    logic [CW-1:0]   wr_len_q, wr_len_d, rd_len_q, rd_len_d;
    logic [CW-1:0]   wr_cnt_q, wr_cnt_d, rd_cnt_q, rd_cnt_d;
    logic [CW-1:0]   wr_cnt_inc, rd_cnt_inc;
    logic [DW-1:0]   wr_data_q, wr_data_d, rd_data_q, rd_data_d;
    logic            err_q, err_d;
    logic [7:0]      write_byte_q, write_byte_d;
    logic [GW-1:0]   gap_q, gap_d;
    logic [1:0]      grant_oh;

    function automatic logic [CW-1:0] clamp_len(input logic [2:0] len);
        if (32'(len) > MAX_BYTES) return CW'(MAX_BYTES);
        return CW'(len);
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            sel_q        <= 1'b0;
            last_q       <= 1'b1;
            wr_len_q     <= '0;
            rd_len_q     <= '0;
            wr_cnt_q     <= '0;
            rd_cnt_q     <= '0;
            wr_data_q    <= '0;
            rd_data_q    <= '0;
            err_q        <= 1'b0;
            write_byte_q <= '0;
            gap_q        <= '0;
        end else begin
            state_q      <= state_d;
            sel_q        <= sel_d;
            last_q       <= last_d;
            wr_len_q     <= wr_len_d;
            rd_len_q     <= rd_len_d;
            wr_cnt_q     <= wr_cnt_d;
            rd_cnt_q     <= rd_cnt_d;
            wr_data_q    <= wr_data_d;
            rd_data_q    <= rd_data_d;
            err_q        <= err_d;
            write_byte_q <= write_byte_d;
            gap_q        <= gap_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        sel_d        = sel_q;
        last_d       = last_q;
        wr_len_d     = wr_len_q;
        rd_len_d     = rd_len_q;
        wr_cnt_d     = wr_cnt_q;
        rd_cnt_d     = rd_cnt_q;
        wr_data_d    = wr_data_q;
        rd_data_d    = rd_data_q;
        err_d        = err_q;
        write_byte_d = write_byte_q;
        gap_d        = gap_q;
        wr_cnt_inc   = wr_cnt_q + CW'(1);
        rd_cnt_inc   = rd_cnt_q + CW'(1);

        case (state_q)
            StIdle: begin
                if (|req) begin
                    // With both requesting, the one not served last wins.
                    sel_d     = (req == 2'b11) ? ~last_q : req[1];
                    wr_len_d  = clamp_len(sel_d ? wr_len1 : wr_len0);
                    rd_len_d  = clamp_len(sel_d ? rd_len1 : rd_len0);
                    wr_data_d = sel_d ? wr_data1 : wr_data0;
                    wr_cnt_d  = '0;
                    rd_cnt_d  = '0;
                    rd_data_d = '0;
                    err_d     = 1'b0;
                    state_d   = StRst;
                end
            end
            StRst: begin
                if (reset_done) begin
                    // Gap states keep every enable low for a cycle so the
                    // engine that just finished can clear its done.
                    if (reset_presence) begin
                        err_d   = 1'b1;
                        state_d = StFin;
                    end else if (wr_len_q != '0) begin
                        state_d = StWrGap;
                    end else if (rd_len_q != '0) begin
                        state_d = StRdGap;
                    end else begin
                        state_d = StFin;
                    end
                end
            end
            StWrGap: begin
                for (int i = 0; i < MAX_BYTES; i++) begin
                    if (wr_cnt_q == CW'(i)) write_byte_d = wr_data_q[8*i +: 8];
                end
                state_d = StWr;
            end
            StWr: begin
                if (write_done) begin
                    wr_cnt_d = wr_cnt_inc;
                    if (wr_cnt_inc == wr_len_q) begin
                        state_d = (rd_len_q != '0) ? StRdGap : StFin;
                    end else begin
                        state_d = StWrGap;
                    end
                end
            end
            StRdGap: begin
                state_d = StRd;
            end
            StRd: begin
                if (read_done) begin
                    for (int i = 0; i < MAX_BYTES; i++) begin
                        if (rd_cnt_q == CW'(i)) rd_data_d[8*i +: 8] = read_byte;
                    end
                    rd_cnt_d = rd_cnt_inc;
                    state_d  = (rd_cnt_inc == rd_len_q) ? StFin : StRdGap;
                end
            end
            StFin: begin
                last_d  = sel_q;
                gap_d   = '0;
                state_d = StRecover;
            end
            StRecover: begin
                if (gap_q == GW'(GAP_CYCLES - 1)) state_d = StIdle;
                else gap_d = gap_q + GW'(1);
            end
            default: state_d = StIdle;
        endcase
    end

    // Grant, done and enables decode straight from the state register, so an
    // asynchronous reset drops them immediately.
    always_comb begin
        grant_oh     = sel_q ? 2'b10 : 2'b01;
        gnt          = 2'b00;
        done         = 2'b00;
        reset_enable = 1'b0;
        write_enable = 1'b0;
        read_enable  = 1'b0;
        case (state_q)
            StRst: begin
                gnt          = grant_oh;
                reset_enable = 1'b1;
            end
            StWrGap, StRdGap: gnt = grant_oh;
            StWr: begin
                gnt          = grant_oh;
                write_enable = 1'b1;
            end
            StRd: begin
                gnt         = grant_oh;
                read_enable = 1'b1;
            end
            StFin:   done = grant_oh;
            default: ;
        endcase
    end

    assign err        = err_q;
    assign rd_data    = rd_data_q;
    assign write_byte = write_byte_q;

endmodule

// File: tb/tb_onewire_bus_scheduler.sv
// Bench for onewire_bus_scheduler: behavioural reset/write/read engines, a
// scoreboard queue filled by the stimulus and drained by a monitor on done.
module tb_onewire_bus_scheduler;

    localparam int unsigned MB  = 4;
    localparam int unsigned GAP = 27;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [1:0]    req = 2'b00;
    logic [2:0]    wr_len0 = 3'd0, wr_len1 = 3'd0, rd_len0 = 3'd0, rd_len1 = 3'd0;
    logic [31:0]   wr_data0 = '0, wr_data1 = '0;
    logic [1:0]    gnt, done;
    logic          err;
    logic [31:0]   rd_data;
    logic          reset_enable, write_enable, read_enable;
    logic          reset_done = 1'b0, reset_presence = 1'b0;
    logic          write_done = 1'b0, read_done = 1'b0;
    logic [7:0]    write_byte;
    logic [7:0]    read_byte = 8'h00;

    onewire_bus_scheduler #(.MAX_BYTES(MB), .GAP_CYCLES(GAP)) dut (
        .clk(clk), .rst_n(rst_n), .req(req),
        .wr_len0(wr_len0), .wr_len1(wr_len1), .rd_len0(rd_len0), .rd_len1(rd_len1),
        .wr_data0(wr_data0), .wr_data1(wr_data1),
        .gnt(gnt), .done(done), .err(err), .rd_data(rd_data),
        .reset_enable(reset_enable), .reset_done(reset_done),
        .reset_presence(reset_presence),
        .write_enable(write_enable), .write_byte(write_byte), .write_done(write_done),
        .read_enable(read_enable), .read_done(read_done), .read_byte(read_byte)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          who;
        logic        err;
        logic [31:0] rd;
        int          nwr;
        logic [31:0] wr;
        int          nrd;
        int          gap;   // idle samples between previous done and this gnt; -1 = unchecked
    } exp_t;

    exp_t        exp_q[$];
    logic [7:0]  rd_src[$];
    logic        presence_val = 1'b0;
    int          n_cmp = 0, n_fail = 0;
    int          wr_seen = 0, rd_seen = 0, viol = 0;
    logic [31:0] wr_log = '0;
    int          rst_lat = 0, wr_lat = 0, rd_lat = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_exp(input int who, input logic e, input logic [31:0] rd,
                            input int nwr, input logic [31:0] wr, input int nrd,
                            input int gap);
        exp_t x;
        x.who = who; x.err = e; x.rd = rd; x.nwr = nwr; x.wr = wr; x.nrd = nrd; x.gap = gap;
        exp_q.push_back(x);
    endtask

    task automatic load_rd(input logic [31:0] bytes, input int n);
        rd_src.delete();
        for (int k = 0; k < n; k++) rd_src.push_back(bytes[8*k +: 8]);
    endtask

    // Engines: done clears while enable is low, asserts after a fixed latency.
    always @(negedge clk) begin
        if (!reset_enable) begin
            reset_done = 1'b0; rst_lat = 0;
        end else if (!reset_done) begin
            rst_lat++;
            if (rst_lat >= 3) begin
                reset_done = 1'b1; reset_presence = presence_val;
            end
        end
        if (!write_enable) begin
            write_done = 1'b0; wr_lat = 0;
        end else if (!write_done) begin
            wr_lat++;
            if (wr_lat >= 2) begin
                write_done = 1'b1;
                if (wr_seen < 4) wr_log[8*wr_seen +: 8] = write_byte;
                wr_seen++;
            end
        end
        if (!read_enable) begin
            read_done = 1'b0; rd_lat = 0;
        end else if (!read_done) begin
            rd_lat++;
            if (rd_lat >= 2) begin
                read_done = 1'b1;
                read_byte = (rd_src.size() > 0) ? rd_src.pop_front() : 8'hEE;
                rd_seen++;
            end
        end
    end

    // Monitor / scoreboard.
    logic [1:0] gnt_prev = 2'b00, done_prev = 2'b00;
    logic [2:0] en_prev = 3'b000;
    int         cyc = 0, last_done = 0;

    always @(negedge clk) begin
        logic [2:0] en;
        exp_t       e;
        cyc++;
        en = {read_enable, write_enable, reset_enable};
        if ($countones(en) > 1 || (en != 3'b000 && en_prev != 3'b000 && en != en_prev)) viol++;
        if (done_prev != 2'b00) check("done_one_cycle", 32'(done), 32'h0);
        if (gnt != 2'b00 && gnt_prev == 2'b00) begin
            wr_seen = 0; rd_seen = 0; wr_log = '0; viol = 0;
            if (exp_q.size() == 0) begin
                check("unexpected_gnt", 32'(gnt), 32'h0);
            end else begin
                check("gnt", 32'(gnt), 32'(1 << exp_q[0].who));
                if (exp_q[0].gap >= 0)
                    check("recover_gap", 32'(cyc - last_done - 1), 32'(exp_q[0].gap));
            end
        end
        if (done != 2'b00) begin
            if (exp_q.size() == 0) begin
                check("unexpected_done", 32'(done), 32'h0);
            end else begin
                e = exp_q.pop_front();
                check("done", 32'(done), 32'(1 << e.who));
                check("gnt_clear_at_done", 32'(gnt), 32'h0);
                check("err", 32'(err), 32'(e.err));
                check("rd_data", rd_data, e.rd);
                check("write_count", 32'(wr_seen), 32'(e.nwr));
                check("write_bytes", wr_log, e.wr);
                check("read_count", 32'(rd_seen), 32'(e.nrd));
                check("enable_spacing", 32'(viol), 32'h0);
            end
            last_done = cyc;
        end
        gnt_prev  = gnt;
        done_prev = done;
        en_prev   = en;
    end

    task automatic wait_done(input int i);
        bit seen = 1'b0;
        for (int k = 0; k < 3000; k++) begin
            @(negedge clk);
            if (done[i]) begin
                seen = 1'b1;
                break;
            end
        end
        check("done_timeout", 32'(seen), 32'h1);
        req[i] = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_gnt"}, 32'(gnt), 32'h0);
        check({tag, "_done"}, 32'(done), 32'h0);
        check({tag, "_err"}, 32'(err), 32'h0);
        check({tag, "_rd_data"}, rd_data, 32'h0);
        check({tag, "_enables"}, 32'({read_enable, write_enable, reset_enable}), 32'h0);
        check({tag, "_write_byte"}, 32'(write_byte), 32'h0);
    endtask

    initial begin
        bit seen;
        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // Contention from reset: 0 wins first, then 1; recovery is GAP cycles
        // plus the IDLE sampling cycle.
        push_exp(0, 1'b0, 32'h0, 0, 32'h0, 0, -1);
        push_exp(1, 1'b0, 32'h0, 0, 32'h0, 0, GAP + 1);
        req = 2'b11;
        wait_done(0);
        wait_done(1);
        push_exp(0, 1'b0, 32'h0, 0, 32'h0, 0, GAP + 1);
        push_exp(1, 1'b0, 32'h0, 0, 32'h0, 0, GAP + 1);
        req = 2'b11;
        wait_done(0);
        wait_done(1);

        // Single request, 2 writes and 2 reads.
        wr_len0 = 3'd2; wr_data0 = 32'hDEAD_BECC; rd_len0 = 3'd2;
        load_rd(32'h0000_0550, 2);
        push_exp(0, 1'b0, 32'h0000_0550, 2, 32'h0000_BECC, 2, -1);
        req[0] = 1'b1;
        wait_done(0);

        // No presence: skip all bytes, err set.
        wr_len1 = 3'd3; wr_data1 = 32'h0102_0304; rd_len1 = 3'd2;
        presence_val = 1'b1;
        push_exp(1, 1'b1, 32'h0, 0, 32'h0, 0, -1);
        req[1] = 1'b1;
        wait_done(1);
        presence_val = 1'b0;

        // Zero writes, read length 7 clamps to 4.
        wr_len0 = 3'd0; rd_len0 = 3'd7;
        load_rd(32'h4433_2211, 4);
        rd_src.push_back(8'h55);
        push_exp(0, 1'b0, 32'h4433_2211, 0, 32'h0, 4, -1);
        req[0] = 1'b1;
        wait_done(0);
        check("clamp_leftover", 32'(rd_src.size()), 32'h1);
        rd_src.delete();

        // Requester drops req during byte 1; transaction still completes.
        wr_len0 = 3'd4; wr_data0 = 32'hA1B2_C3D4; rd_len0 = 3'd1;
        load_rd(32'h0000_0077, 1);
        push_exp(0, 1'b0, 32'h0000_0077, 4, 32'hA1B2_C3D4, 1, -1);
        req[0] = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 1000; k++) begin
            @(negedge clk);
            if (write_enable && wr_seen == 1) begin
                seen = 1'b1;
                break;
            end
        end
        check("byte1_reached", 32'(seen), 32'h1);
        req[0] = 1'b0;
        wait_done(0);

        // Asynchronous reset during the second read byte.
        wr_len0 = 3'd1; wr_data0 = 32'h0000_005A; rd_len0 = 3'd3;
        load_rd(32'h0003_0201, 3);
        push_exp(0, 1'b0, 32'h0, 0, 32'h0, 0, -1);
        req[0] = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 1000; k++) begin
            @(negedge clk);
            if (read_enable && rd_seen == 1) begin
                seen = 1'b1;
                break;
            end
        end
        check("second_read_reached", 32'(seen), 32'h1);
        #2;
        rst_n = 1'b0;
        req   = 2'b00;
        exp_q.delete();
        rd_src.delete();
        #1;
        check_reset_outputs("async_reset");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Normal grant to requester 1 after reset.
        wr_len1 = 3'd1; wr_data1 = 32'h0000_005A; rd_len1 = 3'd1;
        load_rd(32'h0000_00C3, 1);
        push_exp(1, 1'b0, 32'h0000_00C3, 1, 32'h0000_005A, 1, -1);
        req[1] = 1'b1;
        wait_done(1);

        repeat (5) @(negedge clk);
        check("scoreboard_empty", 32'(exp_q.size()), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/onewire_bus_scheduler.md
Name: onewire_bus_scheduler

Overview:
- Byte-level transaction scheduler for the single one-wire bus.
- Shares the bus between two requesters, e.g. a periodic temperature poller and a host command port.
- Runs each granted transaction as: bus reset, presence check, N write bytes, M read bytes.
- Drives the existing reset, byte-write and byte-read engines through their enable/done handshakes. Sits between the requesters and those engines, replacing a hard-wired IDLE→RESET→WRITE→READ sequence.

Parameters:
- MAX_BYTES, 4, maximum write or read bytes per transaction; sets data bus widths (8*MAX_BYTES).
- GAP_CYCLES, 27, idle recovery cycles after each transaction before the next grant (27 = 1 us at 27 MHz).

Ports:
- clk  in  1  system clock, 27 MHz.
- rst_n  in  1  asynchronous active-low reset.
- req  in  2  request per requester; must be held high until that requester's done pulse.
- wr_len0, wr_len1  in  3  write byte count per requester; values above MAX_BYTES are clamped to MAX_BYTES.
- rd_len0, rd_len1  in  3  read byte count per requester; same clamp.
- wr_data0, wr_data1  in  8*MAX_BYTES  write bytes; byte 0 is [7:0] and is sent first.
- gnt  out  2  one-hot grant, held for the whole transaction.
- done  out  2  one-cycle completion pulse to the granted requester.
- err  out  1  no-presence flag; valid with done, held until the next grant.
- rd_data  out  8*MAX_BYTES  read bytes; byte k is at [8k+7:8k]; valid with done, held until the next grant.
- reset_enable  out  1  reset engine enable.
- reset_done  in  1  reset engine done.
- reset_presence  in  1  presence sampled by the reset engine; valid while reset_done is high.
- write_enable  out  1  byte-write engine enable.
- write_byte  out  8  byte to write; stable while write_enable is high.
- write_done  in  1  byte-write engine done.
- read_enable  out  1  byte-read engine enable.
- read_done  in  1  byte-read engine done.
- read_byte  in  8  received byte; valid while read_done is high.

Behaviour:
- Reset values: gnt=0, done=0, err=0, rd_data=0, all enables 0, write_byte=0, state=IDLE, round-robin pointer = last-served 1 (requester 0 wins first).
- Engine contract: an engine clears its done while its enable is low. The scheduler therefore holds each enable low for at least one cycle between consecutive operations, and never has more than one enable high at a time.
- IDLE: when any req bit is high, register the grant.
  - Both high: grant the requester not last served.
  - Latch the clamped lengths and wr_data of the granted requester.
  - Clear rd_data and err.
  - In the cycle after req is sampled: gnt rises, reset_enable rises, go to RST.
- RST: hold reset_enable until reset_done.
  - reset_presence=1: err=1 and go to FIN, skipping all write and read.
  - reset_presence=0: go to WR if wr_len>0, else RD if rd_len>0, else FIN.
  - reset_enable drops in the same transition.
- WR_GAP → WR: write_byte = latched byte k (k counts from 0). Raise write_enable after one gap cycle with all enables low.
  - On write_done: drop write_enable and increment k.
  - If k reaches wr_len: go to RD_GAP if rd_len>0, else FIN.
  - Otherwise go to WR_GAP.
- RD_GAP → RD: the read byte counter restarts at 0. Raise read_enable after one gap cycle.
  - On read_done: store read_byte into rd_data byte k and drop read_enable.
  - If k reaches rd_len: go to FIN. Otherwise go to RD_GAP.
  - Unread upper bytes stay 0.
- FIN: done[granted] pulses for exactly one cycle. gnt clears in the same cycle. Update the last-served pointer. Go to RECOVER.
- RECOVER: count GAP_CYCLES cycles with all enables low, then go to IDLE. No grant is issued during RECOVER even if req is high.
- Requester drops req mid-transaction: the transaction still runs to completion (the bus cannot be aborted) and done still pulses. The scheduler does not re-sample req until IDLE.
- A req pending in RECOVER is served from IDLE on the cycle after RECOVER ends.
- Counters are width clog2(MAX_BYTES+1) bits. No wrap is possible because lengths are clamped.
- Async reset mid-transaction: all enables drop immediately and no done is issued. The engines are expected to release the bus once their enable is low.

Test Plan:
- Single request: req0, wr_len0=2, wr_data0=0x..BE_CC, rd_len0=2, presence=0, read bytes 0x50, 0x05.
  - Expect write_byte sequence 0xCC then 0xBE.
  - Expect rd_data=0x0000_0550, one done[0] pulse, err=0.
  - Expect at least 1 low cycle between consecutive enables.
- No presence: reset_presence=1 at reset_done.
  - Expect write_enable and read_enable never assert.
  - Expect done pulse with err=1 and rd_data=0.
- Contention: req=2'b11 from reset.
  - Expect gnt=01 first, then after its done plus 27 idle cycles gnt=10.
  - Then with req=11 again, expect gnt=01 (alternation).
- Zero and clamped lengths: wr_len=0, rd_len=7.
  - Expect reset, then exactly 4 read bytes, then done.
  - wr_len=0, rd_len=0: expect done directly after reset.
- Req dropped mid-write: deassert req0 during byte 1.
  - Expect remaining bytes written and done[0] still pulses once.
- Async reset mid-read: assert rst_n low during read_enable.
  - Expect all outputs return to reset values asynchronously and no done.
  - After release, a new req1 is granted normally.
